// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 widths, frame marker and loader state encoding
package sap1_pkg;
  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} ld_state_t;
endpackage

// File: rtl/sap1_prog_loader.sv
// sap1_prog_loader: framed byte stream to SAP-1 program RAM writer with run release
module sap1_prog_loader #(
  parameter int ADDR_W = sap1_pkg::SAP1_ADDR_W,
  parameter int DATA_W = sap1_pkg::SAP1_DATA_W,
  parameter logic [DATA_W-1:0] HDR_BYTE = sap1_pkg::HDR_BYTE
) (
  input  logic              clk_in,
  input  logic              limpar_iniciar,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              run_prog,
  output logic              leitura_escrita,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   loaded_count
);
  import sap1_pkg::*;
  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(2 ** ADDR_W);
  ld_state_t state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0] len;
  logic xfer;
  assign xfer = in_valid & in_ready;
  // frame FSM; every output is registered here, ram_we pulses one cycle after each data byte
  always_ff @(posedge clk_in) begin
    if (limpar_iniciar) begin
      state <= S_IDLE;
      in_ready <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      run_prog <= 1'b0;
      leitura_escrita <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      loaded_count <= '0;
      addr <= '0;
      sum <= '0;
      len <= '0;
    end else begin
      in_ready <= 1'b1;
      ram_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (in_data == HDR_BYTE) begin
              state <= S_LEN;
              busy <= 1'b1;
              err <= 1'b0;
              run_prog <= 1'b0;
              leitura_escrita <= 1'b0;
              loaded_count <= '0;
            end
          end
          S_LEN: begin
            if (in_data == '0 || in_data > MAX_LEN) begin
              state <= S_ERR;
              err <= 1'b1;
              busy <= 1'b0;
            end else begin
              len <= in_data[ADDR_W:0];
              addr <= '0;
              sum <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            ram_we <= 1'b1;
            ram_addr <= addr;
            ram_wdata <= in_data;
            addr <= addr + 1'b1;
            sum <= sum + in_data;
            loaded_count <= loaded_count + (ADDR_W+1)'(1);
            if (loaded_count + (ADDR_W+1)'(1) == len) state <= S_CHK;
          end
          S_CHK: begin
            busy <= 1'b0;
            if (in_data == sum) begin
              state <= S_DONE;
              run_prog <= 1'b1;
              leitura_escrita <= 1'b1;
            end else begin
              state <= S_ERR;
              err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sap1_prog_loader.sv
// tb_sap1_prog_loader: frame table plus corner sequences, RAM writes checked via scoreboard
module tb_sap1_prog_loader;
  typedef logic [7:0] q8_t[$];
  typedef struct {
    int n;
    int skip;
    logic [19:0][7:0] b;
    logic e_err;
    logic e_run;
    logic [4:0] e_cnt;
  } vec_t;
  typedef struct packed {
    int cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;
  logic clk = 0;
  logic limpar_iniciar = 1;
  logic in_valid = 0;
  logic [7:0] in_data = '0;
  logic in_ready, ram_we, run_prog, leitura_escrita, busy, err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [4:0] loaded_count;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  wr_t exp_q[$];
  vec_t tbl[$];
  sap1_prog_loader dut (
    .clk_in(clk), .limpar_iniciar(limpar_iniciar), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .run_prog(run_prog), .leitura_escrita(leitura_escrita), .busy(busy), .err(err),
    .loaded_count(loaded_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input q8_t q, input int skip, input logic e_err, input logic e_run,
                              input logic [4:0] e_cnt);
    vec_t v;
    v.n = q.size();
    v.skip = skip;
    v.b = '0;
    for (int i = 0; i < q.size(); i++) v.b[i] = q[i];
    v.e_err = e_err;
    v.e_run = e_run;
    v.e_cnt = e_cnt;
    return v;
  endfunction
  // drives the bytes of v; each in-range data byte is expected on ram_we exactly one cycle later
  task automatic send_frame(input vec_t v, input bit gap);
    int nlen;
    wr_t w;
    nlen = int'(v.b[v.skip+1]);
    for (int i = 0; i < v.n; i++) begin
      if (gap && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1;
      in_data = v.b[i];
      if (nlen >= 1 && nlen <= 16 && i >= v.skip + 2 && i < v.skip + 2 + nlen) begin
        w.cyc = cyc + 1;
        w.addr = 4'(i - v.skip - 2);
        w.data = v.b[i];
        exp_q.push_back(w);
      end
      @(negedge clk);
    end
    in_valid = 0;
    #1;
  endtask
  task automatic st(input string nm, input vec_t v);
    chk({nm, "_err"}, err, v.e_err);
    chk({nm, "_run"}, run_prog, v.e_run);
    chk({nm, "_le"}, leitura_escrita, v.e_run);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_cnt"}, loaded_count, v.e_cnt);
    chk({nm, "_pending"}, exp_q.size(), 0);
  endtask
  // scoreboard pop on every strobe, plus the run/busy/write exclusion rules
  always @(negedge clk) begin
    wr_t e;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", ram_addr, e.addr);
        chk("wr_data", ram_wdata, e.data);
      end
      chk("run_during_we", run_prog | leitura_escrita, 0);
    end
    if (busy) chk("run_during_busy", run_prog | leitura_escrita, 0);
  end
  initial begin
    q8_t q;
    vec_t v;
    q = '{8'h33, 8'hA5, 8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
    tbl.push_back(mk(q, 1, 0, 1, 5'd3));
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    tbl.push_back(mk(q, 0, 1, 0, 5'd2));
    q = '{8'h33, 8'hA5, 8'h01, 8'h42, 8'h42};
    tbl.push_back(mk(q, 1, 0, 1, 5'd1));
    q = '{8'hA5, 8'h00};
    tbl.push_back(mk(q, 0, 1, 0, 5'd0));
    q = '{8'hA5, 8'h11};
    tbl.push_back(mk(q, 0, 1, 0, 5'd0));
    q = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) q.push_back(8'(8'h10 + i));
    q.push_back(8'h78);
    tbl.push_back(mk(q, 0, 0, 1, 5'd16));
    q = '{8'h33, 8'hA5, 8'h02, 8'hAA, 8'hA5, 8'h4F};
    tbl.push_back(mk(q, 1, 0, 1, 5'd2));
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_run", run_prog, 0);
    chk("rst_le", leitura_escrita, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", loaded_count, 0);
    limpar_iniciar = 0;
    @(negedge clk);
    #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    foreach (tbl[i]) begin
      send_frame(tbl[i], 0);
      st($sformatf("vec%0d", i), tbl[i]);
    end
    in_valid = 1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("reload_run", run_prog, 0);
    chk("reload_le", leitura_escrita, 0);
    chk("reload_busy", busy, 1);
    q = '{8'h02, 8'h55, 8'h66, 8'hBB};
    v = mk(q, -1, 0, 1, 5'd2);
    send_frame(v, 0);
    st("reload", v);
    q = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame(mk(q, 0, 0, 0, 5'd2), 0);
    chk("mid_busy", busy, 1);
    limpar_iniciar = 1;
    in_valid = 1;
    in_data = 8'h03;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_run", run_prog, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_cnt", loaded_count, 0);
    chk("midrst_we", ram_we, 0);
    limpar_iniciar = 0;
    in_valid = 0;
    @(negedge clk);
    #1;
    chk("midrst_rel_ready", in_ready, 1);
    chk("midrst_pending", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      send_frame(tbl[0], 1);
      st($sformatf("gap%0d", k), tbl[0]);
      send_frame(tbl[1], 1);
      st($sformatf("gapbad%0d", k), tbl[1]);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("final_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
